io_port_unit: RTL and testbench
===============================

# io_port_unit

Memory-mapped I/O unit between the MIPS processor's data-memory bus and the board pins. It latches processor stores into the 32-bit output port and synchronizes the 8-bit input port. It buffers every input change in a 4-entry FIFO and exposes a status register. Reads and writes are decoded from the processor's `MemWrite`/`MemRead` and ALU address, so the unit sits downstream of the ALU and in parallel with data memory.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h1001_0024, address of PORT_OUT. PORT_IN is at +4 and STATUS at +8.
- `FIFO_DEPTH`, default 4, input-change FIFO depth. Must be a power of 2, at least 2.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `mem_write`  in  1  processor store strobe, one cycle per store.
- `mem_read`  in  1  processor load strobe.
- `address`  in  32  ALU result (byte address).
- `write_data`  in  32  store data.
- `read_data`  out  32  load data. Valid combinationally while `mem_read` and `io_hit` are high.
- `io_hit`  out  1  address equals PORT_OUT, PORT_IN or STATUS. The processor read-data mux uses it to select this unit over data memory.
- `port_in`  in  8  asynchronous board input.
- `port_out`  out  32  registered output port.
- `in_pending`  out  1  FIFO not empty. This is the interrupt/poll flag.

## Operation
- **Address decode.** Compare the full 32 bits. Any other address gives `io_hit`=0 and `read_data`=0.
- **PORT_OUT write.** On `mem_write` with the PORT_OUT address, `port_out` <= `write_data` at the next edge.
- **PORT_OUT read.** Returns the current `port_out`.
- **Input synchronizer.** `port_in` passes through a 2-flop synchronizer (`s1`, `s2`) and then a history register `s3`.
- **Change event.** `s2 != s3`. On a change event, push {`s2`} into the FIFO.
- **PORT_IN read.** Returns {24'b0, FIFO head}, or {24'b0, `s2`} when the FIFO is empty.
  - A read of a non-empty FIFO pops the entry at the next edge.
  - A read of an empty FIFO has no side effect.
- **STATUS read.** Returns {27'b0, overflow, full, count[2:0]}. The read clears `overflow` at the next edge.
- **Writes to PORT_IN and STATUS** are ignored.
- **Full FIFO.** A push while full drops the new sample and sets sticky `overflow`. Existing entries are kept.
- **Simultaneous push and pop when full.** Both occur and the count is unchanged. `overflow` is not set.
- **Simultaneous push and pop when empty.**
  - The pop has no effect, so the read returns the `s2` bypass.
  - The push lands, and count becomes 1.
- **`mem_read` and `mem_write` both high.** The write takes effect. A PORT_IN read side effect still applies.
- **FIFO pointers.** Read and write pointers are log2(`FIFO_DEPTH`) bits and wrap modulo depth. `count` is log2(`FIFO_DEPTH`)+1 bits.

## Timing
- **Reset values** (`reset` low, asynchronous):
  - `port_out`=0
  - `s1`=`s2`=`s3`=0
  - FIFO pointers and count = 0
  - `overflow`=0
  - `in_pending`=0
- **Read path.** `read_data` and `io_hit` are combinational from `address` plus registered state, with zero-cycle load latency. This matches the single-cycle memory stage.
- **Output port.** `port_out` changes one edge after the store cycle.
- **Input path.** A `port_in` change reaches `s2` after 2 edges and is pushed on the 3rd edge. `in_pending` rises 3 edges after the pin change.
- **Pop and clear timing.** Pop and overflow-clear commit on the edge that ends the read cycle.
- **Reset mid-operation.** Asserting reset mid-operation discards FIFO contents immediately.
- **First cycle after reset.** After deassertion, the first edge samples `port_in` into `s1`. No spurious push occurs because `s2`=`s3`=0 until real data propagates.

## Structure
- Shared package `io_port_pkg`:
  - Register offsets OFF_PORT_OUT=0, OFF_PORT_IN=4, OFF_STATUS=8.
  - STATUS bit positions.
  - Default `BASE_ADDR`.
- Sub-module `sync_fifo`, parameterized on width and depth. It has push/pop/full/empty/count and drop-on-full behaviour, and is reusable elsewhere.
- Synchronizer, decode and register logic stay in `io_port_unit`.

## Test plan
1. **Reset.** Hold reset low, drive random `port_in` → `port_out`=0, `in_pending`=0, STATUS read = 0.
2. **Output port.** Store 32'hDEAD_BEEF to BASE_ADDR → `port_out`=32'hDEAD_BEEF one edge later. A load from BASE_ADDR returns the same value, and a store to BASE_ADDR+4 leaves `port_out` unchanged.
3. **Input change.** Change `port_in` 0→3 → `in_pending` rises on the 3rd edge and STATUS=5'b00001. A PORT_IN read returns 3, then count=0, and a PORT_IN read returns the bypass value 3.
4. **Overflow.** Apply 5 input changes (1, 2, 3, 4, 5) spaced 4 cycles apart without reads → STATUS=5'b11100. The next PORT_IN reads return 1, 2, 3, 4. The STATUS read then shows overflow=1, and a second STATUS read shows 0.
5. **Push and pop while full.** With the FIFO full, read PORT_IN on the same edge a change of `port_in` to 8'hA5 is pushed → count stays 4, no overflow, and A5 is the last entry read.
6. **Non-I/O address and mid-operation reset.** Load from 32'h1001_0000 → `io_hit`=0 and `read_data`=0. Assert reset with 2 entries queued → count=0 and `port_out`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_port_pkg.sv
// io_port_pkg: register map, STATUS layout and default base address
// shared by the memory-mapped I/O port unit and its testbench.
package io_port_pkg;

   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1001_0024;

   localparam logic [31:0] OFF_PORT_OUT = 32'd0;
   localparam logic [31:0] OFF_PORT_IN  = 32'd4;
   localparam logic [31:0] OFF_STATUS   = 32'd8;

   localparam int STAT_COUNT_LSB = 0;
   localparam int STAT_COUNT_W   = 3;
   localparam int STAT_FULL      = 3;
   localparam int STAT_OVERFLOW  = 4;

   typedef enum logic [1:0] {
      REG_NONE,
      REG_OUT,
      REG_IN,
      REG_STATUS
   } ioReg_e;

   function automatic logic [31:0] statusWord(
      input logic       ovf,
      input logic       full,
      input logic [2:0] cnt
   );
      logic [31:0] w;
      w = '0;
      w[STAT_OVERFLOW] = ovf;
      w[STAT_FULL] = full;
      w[STAT_COUNT_LSB +: STAT_COUNT_W] = cnt;
      return w;
   endfunction

endpackage

// File: rtl/io_port_unit_sync_fifo.sv
// sync_fifo: single-clock FIFO with drop-on-full push and head peek.
// Ports: clk, reset(async low), push/din, pop, head, full, empty, count, drop.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic                     drop,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rdPtr;
   logic [AW-1:0]    wrPtr;
   logic             doPush;
   logic             doPop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign head  = mem[rdPtr];

   // A pop frees a slot in the same cycle, so a full FIFO still
   // accepts a push that coincides with a pop.
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);
   assign drop   = push && !doPush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (doPop)  rdPtr <= rdPtr + AW'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= din;
   end

endmodule

// File: rtl/io_port_unit.sv
// io_port_unit: memory-mapped PORT_OUT / PORT_IN / STATUS registers
// beside data memory. Ports: clk, reset(async low), mem_write,
// mem_read, address, write_data, read_data, io_hit, port_in,
// port_out, in_pending.
module io_port_unit
   import io_port_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_write,
   input  logic        mem_read,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        io_hit,
   input  logic [7:0]  port_in,
   output logic [31:0] port_out,
   output logic        in_pending
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [7:0]    s1;
   logic [7:0]    s2;
   logic [7:0]    s3;
   ioReg_e        regSel;
   logic          change;
   logic          popReq;
   logic          clrReq;
   logic          overflow;
   logic [7:0]    fifoHead;
   logic          fifoFull;
   logic          fifoEmpty;
   logic          fifoDrop;
   logic [CW-1:0] fifoCount;
   logic [2:0]    countField;

   always_comb begin
      regSel = REG_NONE;
      unique case (1'b1)
         (address == BASE_ADDR + OFF_PORT_OUT): regSel = REG_OUT;
         (address == BASE_ADDR + OFF_PORT_IN):  regSel = REG_IN;
         (address == BASE_ADDR + OFF_STATUS):   regSel = REG_STATUS;
         default:                               regSel = REG_NONE;
      endcase
   end

   assign io_hit = (regSel != REG_NONE);

   // Side effects need mem_read; the data path itself follows the
   // decoded register so a write cycle never disturbs the FIFO.
   assign popReq = mem_read && (regSel == REG_IN);
   assign clrReq = mem_read && (regSel == REG_STATUS);

   assign change     = (s2 != s3);
   assign in_pending = !fifoEmpty;
   assign countField = 3'(fifoCount);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) uFifo (
      .clk   (clk),
      .reset (reset),
      .push  (change),
      .pop   (popReq),
      .din   (s2),
      .head  (fifoHead),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .drop  (fifoDrop),
      .count (fifoCount)
   );

   always_comb begin
      read_data = '0;
      case (regSel)
         REG_OUT:    read_data = port_out;
         REG_IN:     read_data = {24'b0, fifoEmpty ? s2 : fifoHead};
         REG_STATUS: read_data = statusWord(overflow, fifoFull,
                                            countField);
         default:    read_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= port_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         port_out <= '0;
      end else if (mem_write && regSel == REG_OUT) begin
         port_out <= write_data;
      end
   end

   // A fresh drop outranks a clearing STATUS read in the same cycle
   // so the loss is never hidden.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (fifoDrop) begin
         overflow <= 1'b1;
      end else if (clrReq) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_io_port_unit.sv
// tb_io_port_unit: directed plus randomized bench for io_port_unit
// against a queue-based behavioural model.
module tb_io_port_unit;

   localparam logic [31:0] BASE  = 32'h1001_0024;
   localparam int          DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        mem_write = 1'b0;
   logic        mem_read = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        io_hit;
   logic [7:0]  port_in = '0;
   logic [31:0] port_out;
   logic        in_pending;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] mOut;
   logic [7:0]  mS1, mS2, mS3;
   logic        mOvf;
   logic [7:0]  q[$];
   logic [31:0] lastRd;
   logic        lastHit;

   always #5 clk = ~clk;

   io_port_unit #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .mem_write  (mem_write),
      .mem_read   (mem_read),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .io_hit     (io_hit),
      .port_in    (port_in),
      .port_out   (port_out),
      .in_pending (in_pending)
   );

   task automatic modelReset();
      mOut = '0;
      mS1 = '0;
      mS2 = '0;
      mS3 = '0;
      mOvf = 1'b0;
      q.delete();
   endtask

   function automatic logic [31:0] expRead(input logic [31:0] a);
      if (a == BASE) return mOut;
      if (a == BASE + 4)
         return {24'b0, (q.size() > 0) ? q[0] : mS2};
      if (a == BASE + 8)
         return {27'b0, mOvf, q.size() == DEPTH, 3'(q.size())};
      return 32'd0;
   endfunction

   task automatic modelEdge(input logic w, input logic r,
                            input logic [31:0] a, input logic [31:0] wd,
                            input logic [7:0] pin);
      logic pushReq;
      logic [7:0] pd;
      if (!reset) begin
         modelReset();
         return;
      end
      pushReq = (mS2 != mS3);
      pd = mS2;
      if (r && a == BASE + 4 && q.size() > 0) void'(q.pop_front());
      if (r && a == BASE + 8) mOvf = 1'b0;
      if (pushReq) begin
         if (q.size() < DEPTH) q.push_back(pd);
         else mOvf = 1'b1;
      end
      if (w && a == BASE) mOut = wd;
      mS3 = mS2;
      mS2 = mS1;
      mS1 = pin;
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp,
                  $time);
      end
   endtask

   task automatic checkAll();
      logic hitExp;
      hitExp = (address == BASE) || (address == BASE + 4) ||
               (address == BASE + 8);
      chk("port_out", port_out, mOut);
      chk("in_pending", {31'b0, in_pending}, {31'b0, q.size() != 0});
      chk("io_hit", {31'b0, io_hit}, {31'b0, hitExp});
      chk("read_data", read_data, expRead(address));
   endtask

   task automatic cyc(input logic w, input logic r,
                      input logic [31:0] a, input logic [31:0] wd);
      mem_write = w;
      mem_read = r;
      address = a;
      write_data = wd;
      @(negedge clk);
      checkAll();
      lastRd = read_data;
      lastHit = io_hit;
      @(posedge clk);
      modelEdge(w, r, a, wd, port_in);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, BASE, 32'd0);
   endtask

   initial begin
      logic [7:0] fillV [4];
      logic [31:0] a;
      fillV[0] = 8'h22;
      fillV[1] = 8'h33;
      fillV[2] = 8'h44;
      fillV[3] = 8'hA5;
      modelReset();
      #1;

      for (int i = 0; i < 4; i++) begin
         port_in = 8'($urandom);
         cyc(1'b0, 1'b0, BASE, 32'd0);
      end
      port_in = 8'h00;
      cyc(1'b0, 1'b1, BASE + 8, 32'd0);
      chk("reset_status", lastRd, 32'd0);
      chk("reset_port_out", port_out, 32'd0);
      chk("reset_pending", {31'b0, in_pending}, 32'd0);
      reset = 1'b1;
      idle(3);

      cyc(1'b1, 1'b0, BASE, 32'hDEAD_BEEF);
      chk("store_port_out", port_out, 32'hDEAD_BEEF);
      cyc(1'b0, 1'b1, BASE, 32'd0);
      chk("load_port_out", lastRd, 32'hDEAD_BEEF);
      cyc(1'b1, 1'b0, BASE + 4, 32'h1234_5678);
      chk("store_port_in_ignored", port_out, 32'hDEAD_BEEF);

      port_in = 8'h03;
      idle(2);
      chk("pending_edge2", {31'b0, in_pending}, 32'd0);
      idle(1);
      chk("pending_edge3", {31'b0, in_pending}, 32'd1);
      cyc(1'b0, 1'b1, BASE + 8, 32'd0);
      chk("status_one", lastRd, 32'h01);
      cyc(1'b0, 1'b1, BASE + 4, 32'd0);
      chk("port_in_pop", lastRd, 32'h03);
      cyc(1'b0, 1'b1, BASE + 8, 32'd0);
      chk("status_empty", lastRd, 32'h00);
      cyc(1'b0, 1'b1, BASE + 4, 32'd0);
      chk("port_in_bypass", lastRd, 32'h03);

      for (int v = 1; v <= 5; v++) begin
         port_in = 8'(v);
         idle(4);
      end
      cyc(1'b0, 1'b0, BASE + 8, 32'd0);
      chk("status_overflow_full", lastRd, 32'h1C);
      for (int k = 1; k <= 4; k++) begin
         cyc(1'b0, 1'b1, BASE + 4, 32'd0);
         chk("overflow_drain", lastRd, 32'(k));
      end
      cyc(1'b0, 1'b1, BASE + 8, 32'd0);
      chk("status_sticky", lastRd, 32'h10);
      cyc(1'b0, 1'b1, BASE + 8, 32'd0);
      chk("status_cleared", lastRd, 32'h00);

      port_in = 8'h11; idle(4);
      port_in = 8'h22; idle(4);
      port_in = 8'h33; idle(4);
      port_in = 8'h44; idle(4);
      port_in = 8'hA5;
      idle(2);
      cyc(1'b0, 1'b1, BASE + 4, 32'd0);
      chk("full_pushpop_head", lastRd, 32'h11);
      cyc(1'b0, 1'b0, BASE + 8, 32'd0);
      chk("full_pushpop_status", lastRd, 32'h0C);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, 1'b1, BASE + 4, 32'd0);
         chk("full_pushpop_drain", lastRd, {24'b0, fillV[k]});
      end

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 3) == 0) port_in = 8'($urandom);
         case ($urandom_range(0, 5))
            0: a = BASE;
            1: a = BASE + 4;
            2: a = BASE + 8;
            3: a = BASE + 12;
            4: a = 32'h1001_0000;
            default: a = $urandom;
         endcase
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
             a, $urandom);
      end

      idle(4);
      for (int k = 0; k < 8; k++) cyc(1'b0, 1'b1, BASE + 4, 32'd0);
      cyc(1'b0, 1'b1, BASE + 8, 32'd0);
      cyc(1'b1, 1'b0, BASE, 32'hCAFE_F00D);

      cyc(1'b0, 1'b1, 32'h1001_0000, 32'd0);
      chk("non_io_hit", {31'b0, lastHit}, 32'd0);
      chk("non_io_data", lastRd, 32'd0);
      port_in = port_in + 8'd1; idle(4);
      port_in = port_in + 8'd1; idle(4);
      cyc(1'b0, 1'b0, BASE + 8, 32'd0);
      chk("two_queued", lastRd, 32'h02);
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_port_out", port_out, 32'd0);
      chk("async_rst_pending", {31'b0, in_pending}, 32'd0);
      mem_read = 1'b1;
      address = BASE + 8;
      #1;
      chk("async_rst_status", read_data, 32'd0);
      modelReset();
      cyc(1'b0, 1'b0, BASE, 32'd0);
      reset = 1'b1;
      idle(3);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
